bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 21: input word width in bits.
REQ-002 Parameter DIGITS, default 7: number of BCD digits produced.
REQ-003 Parameter SIGNED, default 1: 1 = bin is two's complement, 0 = bin is unsigned.
REQ-004 Parameter BLANK, default 1: 1 = leading-zero digits blanked, 0 = all digits shown.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request a conversion of bin; sampled only when not busy.
REQ-009 bin  input  WIDTH  value to convert; captured on the accepting edge.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse when the result registers update.
REQ-012 bcd  output  4*DIGITS  digit k occupies bits [4k+3:4k]; digit 0 is least significant.
REQ-013 sign_digit  output  4  4'hB (minus glyph) when negative, else 4'hF (blank glyph).
REQ-014 overflow  output  1  high when the magnitude exceeds 10^DIGITS-1.

Function
REQ-015 FSM states are IDLE, SHIFT and DONE.
REQ-016 IDLE or DONE with start=1: go to SHIFT, shift counter = 0, capture the magnitude and sign.
REQ-017 Magnitude is computed at WIDTH bits unsigned, so the most-negative input converts correctly (e.g. -1,048,576 for WIDTH=21).
REQ-018 With SIGNED=0, the sign is forced to 0 and the magnitude equals bin.
REQ-019 In each SHIFT cycle: every digit >= 5 gets +3, then {digits, magnitude} shifts left by one.
REQ-020 SHIFT lasts exactly WIDTH cycles, then the FSM enters DONE for one cycle.
REQ-021 On entry to DONE, bcd, sign_digit and overflow are registered and done=1.
REQ-022 done rises WIDTH+1 edges after the edge that accepted start.
REQ-023 busy is high in SHIFT only and low in IDLE and DONE.
REQ-024 start asserted while busy=1 is ignored, with no queuing.
REQ-025 start in the DONE cycle is accepted, allowing back-to-back conversions every WIDTH+1 cycles.
REQ-026 DONE returns to IDLE when start=0.
REQ-027 overflow is set if any bit shifted out of the top digit during the conversion was 1.
REQ-028 When overflow=1, bcd holds the low DIGITS digits, truncated.
REQ-029 With BLANK=1, every digit above the most significant nonzero digit outputs 4'hF.
REQ-030 Digit 0 is never blanked, so zero displays as "0".
REQ-031 A zero magnitude always gives sign_digit = 4'hF.
REQ-032 bcd, sign_digit and overflow hold their last values until the next done.
REQ-033 bin changes after the accepting edge do not affect the conversion in progress.

Reset
REQ-034 While reset=1 on an edge: FSM goes to IDLE; busy=0; done=0; overflow=0; sign_digit=4'hF.
REQ-035 Reset value of bcd is digit 0 = 4'h0 and every other digit = 4'hF when BLANK=1, or all digits 4'h0 when BLANK=0.
REQ-036 Reset mid-conversion aborts it with no done pulse; outputs take their reset values.
REQ-037 Reset takes priority over a simultaneous start.

Structure
REQ-038 A shared package holds:
- the FSM state enum;
- the glyph constants BLANK_GLYPH=4'hF and MINUS_GLYPH=4'hB;
- a function returning the minimum DIGITS for a given WIDTH and SIGNED.
REQ-039 An elaboration check flags DIGITS < 1 and WIDTH < 2.
REQ-040 One sub-module, bcd_add3, implements the per-digit "if >= 5 add 3" correction and is instantiated DIGITS times.

Verification
REQ-041 Defaults, bin=0 -> after 22 edges: digit0=0, digits1-6=F, sign_digit=F, overflow=0, one done pulse.
REQ-042 Defaults, bin=1048575 -> digits 6..0 = 1,0,4,8,5,7,5, sign_digit=F; bin=-1048576 -> 1,0,4,8,5,7,6, sign_digit=B.
REQ-043 Defaults, bin=-7 -> digit0=7, others F, sign_digit=B; with BLANK=0 -> digits 0,0,0,0,0,0,7.
REQ-044 start pulsed 5 cycles into a conversion of 123 with bin=999 -> result 123, single done, no second conversion.
REQ-045 reset asserted at SHIFT cycle 10 -> no done pulse, reset output values, busy=0; next start converts correctly.
REQ-046 WIDTH=12, DIGITS=3, SIGNED=0, bin=1000 -> overflow=1, digits 0,0,0 then blanked to F,F,0.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_GLYPH = 4'hF;
  localparam logic [3:0] MINUS_GLYPH = 4'hB;

  // Smallest digit count that shows every magnitude of a width-bit input without overflow.
  function automatic int unsigned min_digits(input int unsigned width, input bit is_signed);
    logic [63:0]  mag;
    int unsigned  n;
    mag = is_signed ? (64'd1 << (width - 32'd1)) : ((64'd1 << width) - 64'd1);
    n   = 1;
    for (int i = 0; i < 20; i++) begin
      if (mag >= 64'd10) begin
        mag = mag / 64'd10;
        n   = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// One double-dabble correction step: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q_c
);

  assign q_c = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with sign glyph, overflow flag
// and optional leading-zero blanking; one conversion every WIDTH+1 cycles.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DIGITS = 7,
  parameter bit          SIGNED = 1'b1,
  parameter bit          BLANK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            sign_digit,
  output logic                  overflow
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (DIGITS < 1 || WIDTH < 2) begin : g_param_check
    $error("bin_to_bcd_seq: DIGITS must be >= 1 and WIDTH must be >= 2");
  end

  // Display pattern while no conversion has completed: a lone "0".
  function automatic logic [BW-1:0] bcd_reset();
    logic [BW-1:0] r;
    r = '0;
    for (int k = 1; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = BLANK ? BLANK_GLYPH : 4'h0;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] BCD_RST = bcd_reset();

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     dig;
  logic              neg;
  logic              ovf_acc;

  logic              accept_c;
  logic              neg_in_c;
  logic [WIDTH-1:0]  mag_in_c;
  logic [BW-1:0]     dig_adj_c;
  logic [BW-1:0]     dig_nx_c;
  logic [WIDTH-1:0]  mag_nx_c;
  logic              ovf_nx_c;
  logic [BW-1:0]     bcd_view_c;
  logic              seen_c;

  // Magnitude at full input width so the most-negative value is representable.
  assign neg_in_c = SIGNED & bin[WIDTH-1];
  assign mag_in_c = neg_in_c ? (~bin) + WIDTH'(1) : bin;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .d   (dig[4*k +: 4]),
      .q_c (dig_adj_c[4*k +: 4])
    );
  end

  assign dig_nx_c = {dig_adj_c[BW-2:0], mag[WIDTH-1]};
  assign mag_nx_c = {mag[WIDTH-2:0], 1'b0};
  assign ovf_nx_c = ovf_acc | dig_adj_c[BW-1];

  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    seen_c     = 1'b0;
    bcd_view_c = dig_nx_c;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (dig_nx_c[4*k +: 4] != 4'h0) seen_c = 1'b1;
      if (BLANK && !seen_c) bcd_view_c[4*k +: 4] = BLANK_GLYPH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SHIFT;
          accept_c = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_nx = S_SHIFT;
          accept_c = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift datapath and result registers; results load on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      sign_digit <= BLANK_GLYPH;
      bcd        <= BCD_RST;
      cnt        <= '0;
      mag        <= '0;
      dig        <= '0;
      neg        <= 1'b0;
      ovf_acc    <= 1'b0;
    end else begin
      busy <= (state_nx == S_SHIFT);
      done <= (state == S_SHIFT) && (state_nx == S_DONE);
      if (accept_c) begin
        cnt     <= '0;
        mag     <= mag_in_c;
        dig     <= '0;
        neg     <= neg_in_c;
        ovf_acc <= 1'b0;
      end else if (state == S_SHIFT) begin
        cnt     <= cnt + CW'(1);
        mag     <= mag_nx_c;
        dig     <= dig_nx_c;
        ovf_acc <= ovf_nx_c;
        if (state_nx == S_DONE) begin
          bcd        <= bcd_view_c;
          overflow   <= ovf_nx_c;
          sign_digit <= neg ? MINUS_GLYPH : BLANK_GLYPH;
        end
      end
    end
  end

endmodule
